instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch stage of the 5-stage RISC-V pipeline: owns the program counter, drives the address port of `InstructionMemory` and captures the returned word into the IF/ID pipeline register. It is the requesting side of the `pc`/`instruction` ROM interface. It handles decode stalls, branch/jump redirects from EX, and an EBREAK halt that freezes fetch until the next redirect.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- `NOP_INSTR`, 32'h0000_0013, bubble word (`ADDI x0,x0,0`) placed in IF/ID on flush, reset and halt.
- `EBREAK_INSTR`, 32'h0010_0073, encoding that triggers HALT.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_pc`  out  32  address to `InstructionMemory.pc`.
- `imem_instr`  in  32  word from `InstructionMemory.instruction`; combinational, valid in the same cycle.
- `stall`  in  1  hazard unit hold request.
- `redirect_valid`  in  1  branch taken or jump, from EX.
- `redirect_pc`  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- `if_id_instr`  out  32  registered instruction.
- `if_id_pc`  out  32  registered address of `if_id_instr`.
- `if_id_pc_plus4`  out  32  `if_id_pc + 4`, registered.
- `if_id_valid`  out  1  1 = real instruction, 0 = bubble.
- `halted`  out  1  1 while in HALT.
- `fetch_count`  out  32  number of valid instructions delivered into IF/ID.

## Operation
- State machine:
  - **RUN** — fetching.
  - **HALT** — PC frozen.
- `imem_pc` = `pc_q` (register output, no combinational path from inputs).
- Per-cycle priority (highest first):
  1. **redirect** (`redirect_valid`=1, any state, overrides `stall`):
     - `pc_q` ← {`redirect_pc`[31:2], 2'b00}.
     - IF/ID ← bubble: `if_id_instr`=NOP_INSTR, `if_id_valid`=0; `if_id_pc`/`if_id_pc_plus4` hold.
     - state ← RUN.
     - `fetch_count` unchanged.
  2. **stall** (`stall`=1): `pc_q`, all IF/ID fields, state and `fetch_count` hold.
  3. **RUN advance**:
     - IF/ID ← {`imem_instr`, `pc_q`, `pc_q`+4, valid=1}.
     - `pc_q` ← `pc_q`+4.
     - `fetch_count` ← `fetch_count`+1.
     - If `imem_instr` == EBREAK_INSTR, the EBREAK is still delivered (valid=1) and state ← HALT.
  4. **HALT idle**:
     - IF/ID ← bubble (NOP_INSTR, valid=0).
     - `pc_q` holds at the EBREAK address + 4.
- Arithmetic:
  - All PC math is modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
  - `fetch_count` also wraps modulo 2^32.
- `halted` = (state == HALT), decoded directly from the state register.
- **Reset** (async assert, any time, including mid-stall or mid-halt):
  - `pc_q`=RESET_PC.
  - `if_id_instr`=NOP_INSTR, `if_id_pc`=0, `if_id_pc_plus4`=0, `if_id_valid`=0.
  - `fetch_count`=0, state=RUN, `halted`=0.
  - Outputs change immediately on reset assertion, without waiting for a clock edge.
- **Reset release**: fetch resumes at the first rising edge with `rst_n`=1.

## Timing
- Fetch latency: the word at `imem_pc` in cycle N appears on `if_id_*` after edge N+1.
- Throughput: one instruction per cycle in RUN with no stall or redirect.
- Redirect penalty:
  - The edge that accepts the redirect inserts one bubble.
  - The target instruction is in IF/ID one edge later.
  - The wrong-path word present on `imem_instr` in the redirect cycle is discarded.
- Stall is single-edge precise: an N-cycle stall holds the outputs for exactly N edges.
- Stall and redirect in the same cycle: redirect wins. The bubble is written even though `stall` is high.
- HALT entry: `halted`=1 after the edge that latches the EBREAK. From the following edge onward, `if_id_valid`=0.
- HALT exit: the first redirect edge clears `halted`. There is no other exit except reset.

## Test plan
- **Reset/straight-line fetch**
  - Stimulus: memory model returns 0x00100093 @0, 0x00200113 @4, 0x002081B3 @8, and 0x00000013 elsewhere. Assert reset, then release.
  - Required response:
    - During reset: `imem_pc`=0, `if_id_valid`=0, `if_id_instr`=0x00000013.
    - Edges 1–3: `if_id_instr`/`if_id_pc` = 0x00100093/0, 0x00200113/4, 0x002081B3/8.
    - `fetch_count`=3.
- **Stall**
  - Stimulus: assert `stall` for 2 cycles while `imem_pc`=4.
  - Required response: `imem_pc` stays 4; IF/ID holds 0x00100093/0 for 2 edges; then it advances to 0x00200113/4.
- **Redirect**
  - Stimulus: pulse `redirect_valid` with `redirect_pc`=0x0000_0102 while `imem_pc`=8.
  - Required response:
    - Next edge: `if_id_valid`=0, `if_id_instr`=0x00000013, `imem_pc`=0x100.
    - Edge after that: `if_id_pc`=0x100, valid=1.
- **Redirect + stall same cycle**
  - Stimulus: assert both together.
  - Required response: redirect is taken and the bubble is inserted; `fetch_count` is unchanged.
- **EBREAK halt**
  - Stimulus: 0x00100073 @0xC.
  - Required response:
    - The EBREAK is delivered with valid=1 and `if_id_pc`=0xC.
    - `halted`=1 and `imem_pc`=0x10 frozen for 5 cycles with `if_id_valid`=0.
    - A redirect to 0 clears `halted` and fetch restarts at 0.
- **Wrap and async reset**
  - Stimulus: redirect to 0xFFFF_FFFC, run 2 edges, then assert `rst_n`=0 between edges.
  - Required response:
    - `imem_pc` goes 0xFFFF_FFFC → 0x0000_0000 → 0x0000_0004.
    - On reset assertion, all outputs go to their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction ROM address and fills the IF/ID register.
// Handles decode stalls, EX redirects and an EBREAK halt that freezes fetch until a redirect.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
    parameter logic [31:0] EBREAK_INSTR = 32'h0010_0073
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [31:0] imem_pc_o,
    input  logic [31:0] imem_instr_i,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc_plus4_o,
    output logic        if_id_valid_o,
    output logic        halted_o,
    output logic [31:0] fetch_count_o
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] ifpc4_q, ifpc4_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pcPlus4;

    assign pcPlus4 = pc_q + 32'd4;

    // Priority: redirect beats stall, stall freezes everything, then RUN fetch or HALT bubble.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        ifpc4_d = ifpc4_q;
        valid_d = valid_q;
        count_d = count_q;
        if (redirect_valid_i) begin
            pc_d    = {redirect_pc_i[31:2], 2'b00};
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            state_d = RUN;
        end else if (stall_i) begin
            state_d = state_q;
        end else if (state_q == RUN) begin
            instr_d = imem_instr_i;
            ifpc_d  = pc_q;
            ifpc4_d = pcPlus4;
            valid_d = 1'b1;
            pc_d    = pcPlus4;
            count_d = count_q + 32'd1;
            if (imem_instr_i == EBREAK_INSTR) begin
                state_d = HALT;
            end
        end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            ifpc_q  <= 32'h0;
            ifpc4_q <= 32'h0;
            valid_q <= 1'b0;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            ifpc4_q <= ifpc4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign imem_pc_o        = pc_q;
    assign if_id_instr_o    = instr_q;
    assign if_id_pc_o       = ifpc_q;
    assign if_id_pc_plus4_o = ifpc4_q;
    assign if_id_valid_o    = valid_q;
    assign halted_o         = (state_q == HALT);
    assign fetch_count_o    = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: straight-line fetch, stall, redirect,
// redirect+stall, EBREAK halt/restart, PC wrap and asynchronous reset.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rstN;
    logic [31:0] imemPc;
    logic [31:0] imemInstr;
    logic        stall;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic [31:0] ifIdInstr;
    logic [31:0] ifIdPc;
    logic [31:0] ifIdPcPlus4;
    logic        ifIdValid;
    logic        halted;
    logic [31:0] fetchCount;

    int testCount = 0;
    int failCount = 0;

    instruction_fetch_unit dut (
        .clk_i            (clk),
        .rst_ni           (rstN),
        .imem_pc_o        (imemPc),
        .imem_instr_i     (imemInstr),
        .stall_i          (stall),
        .redirect_valid_i (redirectValid),
        .redirect_pc_i    (redirectPc),
        .if_id_instr_o    (ifIdInstr),
        .if_id_pc_o       (ifIdPc),
        .if_id_pc_plus4_o (ifIdPcPlus4),
        .if_id_valid_o    (ifIdValid),
        .halted_o         (halted),
        .fetch_count_o    (fetchCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small ROM model: program at 0..0xC, NOP everywhere else.
    always_comb begin
        case (imemPc)
            32'h0000_0000: imemInstr = 32'h0010_0093;
            32'h0000_0004: imemInstr = 32'h0020_0113;
            32'h0000_0008: imemInstr = 32'h0020_81B3;
            32'h0000_000C: imemInstr = 32'h0010_0073;
            default:       imemInstr = NOP;
        endcase
    end

    task automatic applyStimulus(input logic stallIn, input logic redirIn, input logic [31:0] redirPcIn);
        stall         = stallIn;
        redirectValid = redirIn;
        redirectPc    = redirPcIn;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIfId(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                             input logic valid, input logic [31:0] nextPc, input logic [31:0] count);
        checkOutput({tag, ".instr"}, ifIdInstr, instr);
        checkOutput({tag, ".pc"}, ifIdPc, pc);
        checkOutput({tag, ".valid"}, {31'b0, ifIdValid}, {31'b0, valid});
        checkOutput({tag, ".imemPc"}, imemPc, nextPc);
        checkOutput({tag, ".count"}, fetchCount, count);
    endtask

    initial begin
        rstN = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        #1 rstN = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("rst.imemPc", imemPc, 32'h0);
        checkOutput("rst.valid", {31'b0, ifIdValid}, 32'h0);
        checkOutput("rst.instr", ifIdInstr, NOP);
        checkOutput("rst.halted", {31'b0, halted}, 32'h0);
        checkOutput("rst.count", fetchCount, 32'h0);
        rstN = 1'b1;

        // Straight-line fetch
        stepEdge();
        checkIfId("line1", 32'h0010_0093, 32'h0, 1'b1, 32'h4, 32'd1);
        checkOutput("line1.plus4", ifIdPcPlus4, 32'h4);
        stepEdge();
        checkIfId("line2", 32'h0020_0113, 32'h4, 1'b1, 32'h8, 32'd2);
        stepEdge();
        checkIfId("line3", 32'h0020_81B3, 32'h8, 1'b1, 32'hC, 32'd3);
        checkOutput("line3.plus4", ifIdPcPlus4, 32'hC);

        // Restart from reset, then stall two cycles at imem_pc = 4
        rstN = 1'b0;
        #2 rstN = 1'b1;
        stepEdge();
        checkIfId("preStall", 32'h0010_0093, 32'h0, 1'b1, 32'h4, 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h0);
        stepEdge();
        checkIfId("stall1", 32'h0010_0093, 32'h0, 1'b1, 32'h4, 32'd1);
        stepEdge();
        checkIfId("stall2", 32'h0010_0093, 32'h0, 1'b1, 32'h4, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0);
        stepEdge();
        checkIfId("postStall", 32'h0020_0113, 32'h4, 1'b1, 32'h8, 32'd2);

        // Redirect to 0x102 while imem_pc = 8: low bits dropped, one bubble
        applyStimulus(1'b0, 1'b1, 32'h0000_0102);
        stepEdge();
        checkIfId("redir", NOP, 32'h4, 1'b0, 32'h100, 32'd2);
        applyStimulus(1'b0, 1'b0, 32'h0);
        stepEdge();
        checkIfId("redirTgt", NOP, 32'h100, 1'b1, 32'h104, 32'd3);
        checkOutput("redirTgt.plus4", ifIdPcPlus4, 32'h104);

        // Redirect and stall together: redirect wins
        applyStimulus(1'b1, 1'b1, 32'h0000_0008);
        stepEdge();
        checkIfId("redirStall", NOP, 32'h100, 1'b0, 32'h8, 32'd3);
        applyStimulus(1'b0, 1'b0, 32'h0);
        stepEdge();
        checkIfId("afterRS", 32'h0020_81B3, 32'h8, 1'b1, 32'hC, 32'd4);

        // EBREAK at 0xC: delivered valid, then HALT with bubbles
        stepEdge();
        checkIfId("ebreak", 32'h0010_0073, 32'hC, 1'b1, 32'h10, 32'd5);
        checkOutput("ebreak.halted", {31'b0, halted}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            stepEdge();
            checkIfId("halt", NOP, 32'hC, 1'b0, 32'h10, 32'd5);
            checkOutput("halt.halted", {31'b0, halted}, 32'h1);
        end
        applyStimulus(1'b0, 1'b1, 32'h0);
        stepEdge();
        checkIfId("unhalt", NOP, 32'hC, 1'b0, 32'h0, 32'd5);
        checkOutput("unhalt.halted", {31'b0, halted}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        stepEdge();
        checkIfId("restart", 32'h0010_0093, 32'h0, 1'b1, 32'h4, 32'd6);

        // PC wrap at the top of the address space
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF);
        stepEdge();
        checkIfId("wrapRedir", NOP, 32'h0, 1'b0, 32'hFFFF_FFFC, 32'd6);
        applyStimulus(1'b0, 1'b0, 32'h0);
        stepEdge();
        checkIfId("wrap1", NOP, 32'hFFFF_FFFC, 1'b1, 32'h0, 32'd7);
        checkOutput("wrap1.plus4", ifIdPcPlus4, 32'h0);
        stepEdge();
        checkIfId("wrap2", 32'h0010_0093, 32'h0, 1'b1, 32'h4, 32'd8);

        // Asynchronous reset between edges
        #2 rstN = 1'b0;
        #1;
        checkIfId("asyncRst", NOP, 32'h0, 1'b0, 32'h0, 32'd0);
        checkOutput("asyncRst.plus4", ifIdPcPlus4, 32'h0);
        checkOutput("asyncRst.halted", {31'b0, halted}, 32'h0);
        rstN = 1'b1;
        stepEdge();
        checkIfId("postRst", 32'h0010_0093, 32'h0, 1'b1, 32'h4, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
